dmem_responder: RTL

Multi-cycle data-memory responder for the 5-stage RISC-V core: the target side of the memory-stage load/store interface. It accepts one request at a time from the memory stage. It performs RV32I byte, halfword and word accesses with byte-lane steering and sign/zero extension, and returns a registered response after a programmable number of wait cycles. While a request is outstanding it drives `stall` to freeze the pipeline.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_align.sv | 69 ++++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Imported by the top and by the lane-alignment datapath.
package dmem_pkg;

  localparam int unsigned CntWidth = 3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32I loads/stores: store byte enables and lane-shifted
// write data, load extraction with sign/zero extension, and alignment/funct3 errors.
module dmem_align
  import dmem_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_be    = 4'b0000;
    o_wword = 32'h0;
    o_rdata = 32'h0;
    o_err   = 1'b0;
    if (i_write) begin
      case (i_funct3)
        F3_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wword = {4{i_wdata[7:0]}};
        end
        F3_H: begin
          o_err   = i_addr_lo[0];
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wword = {2{i_wdata[15:0]}};
        end
        F3_W: begin
          o_err   = |i_addr_lo;
          o_be    = 4'b1111;
          o_wword = i_wdata;
        end
        default: o_err = 1'b1;
      endcase
      // An erroring store must leave memory untouched.
      if (o_err) o_be = 4'b0000;
    end else begin
      case (i_funct3)
        F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_BU: o_rdata = {24'h0, w_byte};
        F3_H: begin
          o_err   = i_addr_lo[0];
          o_rdata = {{16{w_half[15]}}, w_half};
        end
        F3_HU: begin
          o_err   = i_addr_lo[0];
          o_rdata = {16'h0, w_half};
        end
        F3_W: begin
          o_err   = |i_addr_lo;
          o_rdata = i_rword;
        end
        default: o_err = 1'b1;
      endcase
      if (o_err) o_rdata = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches one load/store, waits LATENCY cycles,
// performs the access on the edge into RESP and pulses a registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_stall
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  state_e r_state, w_state_next;

  logic [CntWidth-1:0] r_cnt;
  logic                r_write;
  logic [2:0]          r_funct3;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_write;
  logic [2:0]       w_funct3;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [AddrW-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wword;
  logic [31:0]      w_rdata;
  logic             w_err;
  logic             w_unused_addr;

  assign w_accept     = (r_state == S_IDLE) && i_req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == CntWidth'(1)));

  // With LATENCY=0 the access happens in the accept cycle, before fields are latched.
  assign w_write  = (r_state == S_IDLE) ? i_req_write  : r_write;
  assign w_funct3 = (r_state == S_IDLE) ? i_req_funct3 : r_funct3;
  assign w_addr   = (r_state == S_IDLE) ? i_req_addr   : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata  : r_wdata;
  assign w_idx    = w_addr[AddrW+1:2];
  assign w_unused_addr = ^w_addr[31:AddrW+2];

  dmem_align u_align (
    .i_write   (w_write),
    .i_funct3  (w_funct3),
    .i_addr_lo (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_rdata   (w_rdata),
    .o_err     (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_req_valid) w_state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == CntWidth'(1)) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == S_IDLE);
    o_rsp_valid = (r_state == S_RESP);
  end

  assign o_stall     = i_req_valid & ~o_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CntWidth'(LATENCY);
        r_write  <= i_req_write;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
      if (w_enter_resp) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
    end
  end

  // Memory is deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_enter_resp && w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

endmodule
